// File: rtl/clk_div_checker.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_checker
//  Description : Monitors one divided clock in the clk domain; measures period
//                and high time, checks period against an expected ratio and
//                reports lock, mismatch and stuck-signal errors.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_checker #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int c_mw = $clog2(LOCK_N + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_meas = 2'd2;
    localparam logic [1:0] c_st_lock = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [ERR_W-1:0] c_err_max  = '1;
    localparam logic [c_mw-1:0]  c_lock_n   = c_mw'(LOCK_N);
    localparam logic [c_mw-1:0]  c_lock_nm1 = c_mw'(LOCK_N - 1);

    logic [1:0]       r_state;
    logic             r_s0, r_s1;
    logic [CNT_W-1:0] r_cnt, r_hcnt, r_exp;
    logic [c_mw-1:0]  r_match;
    logic [CNT_W-1:0] r_period, r_high_time;
    logic             r_period_valid, r_locked, r_err;
    logic [ERR_W-1:0] r_err_count;

    logic w_rise, w_fall, w_active, w_match, w_sat, w_err_ev;

    assign w_rise   = r_s0 & ~r_s1;
    assign w_fall   = ~r_s0 & r_s1;
    assign w_active = (r_state == c_st_meas) || (r_state == c_st_lock);
    assign w_match  = (r_cnt == r_exp);
    assign w_sat    = (r_cnt == c_cnt_max);
    // A rise in the saturation cycle is a normal period check, not a stuck event.
    assign w_err_ev = en & w_active & ((w_rise & ~w_match) | (~w_rise & w_sat));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_s0           <= 1'b0;
            r_s1           <= 1'b0;
            r_cnt          <= '0;
            r_hcnt         <= '0;
            r_exp          <= '0;
            r_match        <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_err          <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_s0           <= div_in;
            r_s1           <= r_s0;
            r_period_valid <= 1'b0;

            if (w_err_ev) begin
                r_err <= 1'b1;
                if (r_err_count != c_err_max) r_err_count <= r_err_count + 1'b1;
            end

            if (!en) begin
                r_state  <= c_st_idle;
                r_cnt    <= '0;
                r_hcnt   <= '0;
                r_match  <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_state <= c_st_wait;
                        r_exp   <= exp_period;
                    end
                    c_st_wait: begin
                        if (w_rise) begin
                            r_state <= c_st_meas;
                            r_cnt   <= CNT_W'(1);
                            r_hcnt  <= CNT_W'(1);
                        end else begin
                            r_hcnt  <= '0;
                        end
                    end
                    default: begin
                        if (w_fall) begin
                            r_high_time <= r_hcnt;
                            r_hcnt      <= '0;
                        end else if (r_s0 && r_hcnt != c_cnt_max) begin
                            r_hcnt      <= r_hcnt + 1'b1;
                        end

                        if (w_rise) begin
                            r_period       <= r_cnt;
                            r_period_valid <= 1'b1;
                            r_cnt          <= CNT_W'(1);
                            if (w_match) begin
                                if (r_match >= c_lock_nm1) begin
                                    r_match  <= c_lock_n;
                                    r_state  <= c_st_lock;
                                    r_locked <= 1'b1;
                                end else begin
                                    r_match  <= r_match + 1'b1;
                                end
                            end else begin
                                r_match  <= '0;
                                r_state  <= c_st_meas;
                                r_locked <= 1'b0;
                            end
                        end else if (w_sat) begin
                            // Stuck input: report once, then resync on the next rise.
                            r_state  <= c_st_wait;
                            r_cnt    <= '0;
                            r_hcnt   <= '0;
                            r_match  <= '0;
                            r_locked <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign err          = r_err;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_checker
//  Description : Self-checking bench for clk_div_checker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_checker;

    logic       clk = 1'b0;
    logic       rst, en, div_in;
    logic [7:0] exp_period;
    logic [7:0] period, high_time, err_count;
    logic       period_valid, locked, err;

    clk_div_checker #(.CNT_W(8), .LOCK_N(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .exp_period(exp_period),
        .period(period), .high_time(high_time), .period_valid(period_valid),
        .locked(locked), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h0, l0, h1, l1, expp, nper;
        int e_locked, e_err, e_errcnt, e_high;
    } vec_t;

    vec_t vecs[4];
    int   sb[$];
    bit   started;
    int   prev_len;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // One clock: drive div_in after the edge, sample outputs on the falling edge.
    task automatic step(input logic d);
        div_in = d;
        @(negedge clk);
        if (period_valid) begin
            if (sb.size() == 0) check("spurious_period_valid", int'(period_valid), 0);
            else                check("period", int'(period), sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int h, input int l);
        if (started) sb.push_back(prev_len);
        started  = 1'b1;
        prev_len = h + l;
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic do_reset(input int cycles, input logic en_v);
        rst = 1'b1;
        en  = en_v;
        repeat (cycles) step(1'b0);
        rst = 1'b0;
        sb.delete();
        started = 1'b0;
        @(negedge clk);
        check("rst_period",       int'(period),       0);
        check("rst_high_time",    int'(high_time),    0);
        check("rst_period_valid", int'(period_valid), 0);
        check("rst_locked",       int'(locked),       0);
        check("rst_err",          int'(err),          0);
        check("rst_err_count",    int'(err_count),    0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ec0;
        int n;
        rst = 1'b1; en = 1'b0; div_in = 1'b0; exp_period = 8'd0;
        started = 1'b0; prev_len = 0;
        @(posedge clk);
        #1;

        vecs[0] = '{1, 1, 1, 1, 2, 8, 1, 0, 0, 1};   // div-by-2
        vecs[1] = '{1, 2, 2, 1, 3, 8, 1, 0, 0, 2};   // div-by-3, high alternates 1/2
        vecs[2] = '{2, 3, 2, 3, 5, 6, 1, 0, 0, 2};   // div-by-5
        vecs[3] = '{1, 1, 1, 1, 3, 5, 0, 1, 4, 1};   // div-by-2 against ratio 3

        for (int i = 0; i < 4; i++) begin
            do_reset(2, 1'b0);
            exp_period = 8'(vecs[i].expp);
            en = 1'b1;
            step(1'b0);
            step(1'b0);
            for (int k = 0; k < vecs[i].nper; k++) begin
                if (k % 2 == 0) drive_period(vecs[i].h0, vecs[i].l0);
                else            drive_period(vecs[i].h1, vecs[i].l1);
            end
            repeat (4) step(1'b0);
            check("vec_locked",    int'(locked),    vecs[i].e_locked);
            check("vec_err",       int'(err),       vecs[i].e_err);
            check("vec_err_count", int'(err_count), vecs[i].e_errcnt);
            check("vec_high_time", int'(high_time), vecs[i].e_high);
            check("vec_sb_drained", sb.size(),      0);
        end

        // Lock on div-by-5, one short period, then relock; exp_period change ignored.
        do_reset(2, 1'b0);
        exp_period = 8'd5;
        en = 1'b1;
        step(1'b0);
        step(1'b0);
        exp_period = 8'd9;
        repeat (6) drive_period(2, 3);
        check("a_locked", int'(locked), 1);
        drive_period(2, 2);
        drive_period(2, 3);
        check("a_unlocked",     int'(locked),    0);
        check("a_err",          int'(err),       1);
        check("a_err_count",    int'(err_count), 1);
        repeat (4) drive_period(2, 3);
        check("a_relock", int'(locked), 1);
        exp_period = 8'd5;

        // Stuck low after lock.
        ec0 = int'(err_count);
        n = 0;
        while (int'(err_count) == ec0 && n < 300) begin
            step(1'b0);
            n++;
        end
        check("b_stuck_event",   int'(err_count), ec0 + 1);
        check("b_stuck_latency", int'(n >= 240 && n <= 260), 1);
        started = 1'b0;
        check("b_locked_dropped", int'(locked), 0);
        repeat (300) step(1'b0);
        check("b_single_event", int'(err_count), ec0 + 1);
        repeat (6) drive_period(2, 3);
        check("b_relock", int'(locked), 1);

        // en dropped mid-period.
        ec0 = int'(err_count);
        sb.push_back(prev_len);
        step(1'b1);
        step(1'b1);
        en = 1'b0;
        step(1'b0);
        started = 1'b0;
        step(1'b0);
        step(1'b0);
        check("c_idle_locked",    int'(locked),    0);
        check("c_err_kept",       int'(err),       1);
        check("c_err_count_kept", int'(err_count), ec0);
        en = 1'b1;
        repeat (3) step(1'b0);
        repeat (6) drive_period(2, 3);
        check("c_relock", int'(locked), 1);

        // One-cycle reset while locked with err set.
        check("d_pre_err", int'(err), 1);
        do_reset(1, 1'b1);
        step(1'b0);
        step(1'b0);
        repeat (6) drive_period(2, 3);
        check("d_relock",     int'(locked),    1);
        check("d_err",        int'(err),       0);
        check("d_err_count",  int'(err_count), 0);

        repeat (4) step(1'b0);
        check("final_sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
